// File: rtl/echo_delay.sv
// echo_delay: circular-RAM echo engine. Offset-binary samples go in, and
// sample n is mixed with the line content from sample n-offset. A scaled
// copy of that mix is written back into the line so repeats decay. A fill
// counter keeps RAM contents left over from before reset away from the output.
module echo_delay #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int GAIN_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [GAIN_WIDTH-1:0]    fb_gain,
    input  logic [GAIN_WIDTH-1:0]    mix_gain,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int PW    = DATA_WIDTH + GAIN_WIDTH + 1;   // product width
    localparam int SW    = DATA_WIDTH + 1;                // sum width

    localparam logic [ADDRESS_WIDTH-1:0] FILL_MAX = '1;
    localparam logic [DATA_WIDTH-1:0]    MID      = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // Clamp a one-bit-wider sum back into the sample range.
    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v[SW-1] != v[SW-2])
            return v[SW-1] ? S_MIN : S_MAX;
        return v[DATA_WIDTH-1:0];
    endfunction

    // Write-side bookkeeping (reflects samples already written).
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [ADDRESS_WIDTH-1:0] fill;

    // Stage 1: sample accepted, RAM read in flight.
    logic                          p1_valid;
    logic signed [DATA_WIDTH-1:0]  p1_s;
    logic [GAIN_WIDTH-1:0]         p1_fb;
    logic [GAIN_WIDTH-1:0]         p1_mix;
    logic [ADDRESS_WIDTH-1:0]      p1_addr;
    logic                          p1_ok;
    logic                          p1_byp;
    logic signed [DATA_WIDTH-1:0]  p1_byp_data;
    logic signed [DATA_WIDTH-1:0]  ram_q;

    // Stage 2: mixed output waiting to be presented.
    logic                          p2_valid;
    logic [DATA_WIDTH-1:0]         p2_y;

    logic signed [DATA_WIDTH-1:0]  ram [DEPTH];

    // Acceptance-side view: a sample still in stage 1 counts as written.
    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic [ADDRESS_WIDTH-1:0] fill_eff;
    logic [ADDRESS_WIDTH-1:0] fill_inc;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     echo_ok;

    // Stage-1 arithmetic.
    logic signed [DATA_WIDTH-1:0] d;
    logic signed [PW-1:0]         d_ext;
    logic signed [PW-1:0]         fb_prod;
    logic signed [PW-1:0]         mix_prod;
    logic signed [SW-1:0]         w_sum;
    logic signed [SW-1:0]         y_sum;
    logic signed [DATA_WIDTH-1:0] w;
    logic signed [DATA_WIDTH-1:0] y;

    // Address/fill that the next accepted sample sees, and its read address.
    always_comb begin
        fill_inc  = (fill == FILL_MAX) ? fill : fill + 1'b1;
        next_addr = p1_valid ? p1_addr + 1'b1 : wr_addr;
        fill_eff  = p1_valid ? fill_inc : fill;
        rd_addr   = next_addr - offset;
        echo_ok   = (offset != '0) && (offset <= fill_eff);
    end

    // Delayed sample (or bypassed write value), scaled and mixed with the input.
    always_comb begin
        d        = p1_ok ? (p1_byp ? p1_byp_data : ram_q) : '0;
        d_ext    = {{(PW-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
        fb_prod  = d_ext * $signed({{(PW-GAIN_WIDTH){1'b0}}, p1_fb});
        mix_prod = d_ext * $signed({{(PW-GAIN_WIDTH){1'b0}}, p1_mix});
        w_sum    = {p1_s[DATA_WIDTH-1], p1_s} + SW'(fb_prod >>> GAIN_WIDTH);
        y_sum    = {p1_s[DATA_WIDTH-1], p1_s} + SW'(mix_prod >>> GAIN_WIDTH);
        w        = sat(w_sum);
        y        = sat(y_sum);
    end

    // Delay-line RAM: synchronous read at acceptance, write of the feedback value.
    // NOTE: the RAM has no reset; it maps to block RAM, and the fill guard is
    // what keeps its stale contents from being used.
    always_ff @(posedge clk) begin
        if (en && !rst)
            ram_q <= ram[rd_addr];
        if (p1_valid && !rst)
            ram[p1_addr] <= w;
    end

    // Datapath registers with no reset: only consumed when a valid bit says so.
    always_ff @(posedge clk) begin
        if (en) begin
            p1_s        <= $signed(din ^ MID);
            p1_fb       <= fb_gain;
            p1_mix      <= mix_gain;
            p1_addr     <= next_addr;
            p1_ok       <= echo_ok;
            p1_byp      <= p1_valid && (rd_addr == p1_addr);
            p1_byp_data <= w;
        end
        if (p1_valid)
            p2_y <= y ^ MID;
    end

    // Control: valid pipeline, write pointer, fill counter and output register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= '0;
            fill       <= '0;
            p1_valid   <= 1'b0;
            p2_valid   <= 1'b0;
            dout       <= MID;
            dout_valid <= 1'b0;
        end else begin
            p1_valid   <= en;
            p2_valid   <= p1_valid;
            dout_valid <= p2_valid;
            if (p1_valid) begin
                wr_addr <= p1_addr + 1'b1;
                fill    <= fill_inc;
            end
            if (p2_valid)
                dout <= p2_y;
        end
    end

endmodule

// File: tb/tb_echo_delay.sv
// tb_echo_delay: drives echo_delay (16-deep line) with directed and random
// sample streams and compares every cycle against a sample-history model.
module tb_echo_delay;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int GW   = 4;
    localparam int MAXF = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [DW-1:0] din = 8'h80;
    logic [AW-1:0] offset   = '0;
    logic [GW-1:0] fb_gain  = '0;
    logic [GW-1:0] mix_gain = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;

    echo_delay #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .GAIN_WIDTH(GW)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .offset(offset),
        .fb_gain(fb_gain), .mix_gain(mix_gain), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int y; } pend_t;
    pend_t pq[$];
    int    hist[$];            // feedback value written for each sample since reset
    int    cyc = 0;
    int    exp_dout  = 128;
    int    exp_valid = 0;

    function automatic int satf(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hist.delete();
            pq.delete();
            exp_dout  = 128;
            exp_valid = 0;
        end else begin
            exp_valid = 0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                exp_dout  = pq[0].y;
                exp_valid = 1;
                void'(pq.pop_front());
            end
            if (en) begin
                int n, f, s, off, dd, wv, yv;
                n   = hist.size();
                f   = (n > MAXF) ? MAXF : n;
                off = int'(offset);
                s   = int'(din) - 128;
                dd  = (off != 0 && off <= f) ? hist[n - off] : 0;
                wv  = satf(s + ((dd * int'(fb_gain)) >>> GW));
                yv  = satf(s + ((dd * int'(mix_gain)) >>> GW));
                hist.push_back(wv);
                pq.push_back('{cyc + 2, yv + 128});
            end
        end
    end

    // ---------------- per-cycle compare + capture ----------------
    int pulses = 0;
    int cap[$];

    always @(negedge clk) begin
        check("dout", int'(dout), exp_dout);
        check("dout_valid", int'(dout_valid), exp_valid);
        if (dout_valid) begin
            pulses++;
            cap.push_back(int'(dout));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic e, input logic [DW-1:0] d);
        @(negedge clk);
        en  = e;
        din = d;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 8'($urandom));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settings(input int off, input int fb, input int mix);
        offset   = AW'(off);
        fb_gain  = GW'(fb);
        mix_gain = GW'(mix);
    endtask

    function automatic int cap_at(input int i);
        return (i < cap.size()) ? cap[i] : -1;
    endfunction

    initial begin
        int e[$];
        int pc0;

        // Reset and first-sample latency
        settings(4, 0, 0);
        do_reset(2);
        check("reset_dout", int'(dout), 8'h80);
        check("reset_valid", int'(dout_valid), 0);
        send(1'b1, 8'hC0);
        send(1'b0, 8'h80);
        check("lat_edge1", int'(dout_valid), 0);
        send(1'b0, 8'h80);
        check("lat_edge2", int'(dout_valid), 0);
        send(1'b0, 8'h80);
        check("lat_edge3_valid", int'(dout_valid), 1);
        check("lat_edge3_dout", int'(dout), 8'hC0);
        idle(2);

        // Impulse, no feedback
        settings(4, 0, 8);
        do_reset(2);
        cap.delete();
        send(1'b1, 8'hC0);
        repeat (10) send(1'b1, 8'h80);
        idle(4);
        e = '{8'hC0, 8'h80, 8'h80, 8'h80, 8'hA0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        check("impulse_count", cap.size(), 11);
        for (int i = 0; i < 11; i++) check($sformatf("impulse[%0d]", i), cap_at(i), e[i]);

        // Feedback decay
        settings(2, 8, 15);
        do_reset(2);
        cap.delete();
        send(1'b1, 8'hC0);
        repeat (9) send(1'b1, 8'h80);
        idle(4);
        e = '{8'hC0, 8'h80, 8'hBC, 8'h80, 8'h9E, 8'h80, 8'h8F};
        for (int i = 0; i < 7; i++) check($sformatf("decay[%0d]", i), cap_at(i), e[i]);

        // Saturation high and low
        settings(1, 15, 15);
        do_reset(2);
        cap.delete();
        repeat (20) send(1'b1, 8'hFF);
        idle(4);
        check("sat_hi_count", cap.size(), 20);
        for (int i = 0; i < 20; i++) check($sformatf("sat_hi[%0d]", i), cap_at(i), 8'hFF);
        do_reset(2);
        cap.delete();
        repeat (20) send(1'b1, 8'h00);
        idle(4);
        for (int i = 0; i < 20; i++) check($sformatf("sat_lo[%0d]", i), cap_at(i), 8'h00);

        // Bypass: back-to-back, offset 1
        settings(1, 0, 8);
        do_reset(2);
        cap.delete();
        for (int i = 0; i < 12; i++) send(1'b1, (i % 2 == 0) ? 8'hC0 : 8'h40);
        idle(4);
        for (int i = 0; i < 12; i++)
            check($sformatf("bypass[%0d]", i), cap_at(i),
                  (i == 0) ? 8'hC0 : ((i % 2 == 1) ? 8'h60 : 8'hA0));

        // Wrap: offset 15 across several laps of a 16-deep line
        settings(15, 8, 8);
        do_reset(2);
        cap.delete();
        send(1'b1, 8'hC0);
        repeat (39) send(1'b1, 8'h80);
        idle(4);
        check("wrap_count", cap.size(), 40);
        check("wrap[14]", cap_at(14), 8'h80);
        check("wrap[15]", cap_at(15), 8'hA0);
        check("wrap[16]", cap_at(16), 8'h80);
        check("wrap[29]", cap_at(29), 8'h80);
        check("wrap[30]", cap_at(30), 8'h90);
        check("wrap[31]", cap_at(31), 8'h80);

        // Gapped strobe: one sample every third cycle
        settings(2, 6, 11);
        do_reset(2);
        pc0 = pulses;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 8'($urandom));
            idle(2);
        end
        idle(4);
        check("gapped_pulses", pulses - pc0, 10);

        // Reset with two samples in flight, then fill guard over stale RAM
        settings(4, 0, 0);
        repeat (20) send(1'b1, 8'hC0);
        idle(4);
        pc0 = pulses;
        send(1'b1, 8'hC0);
        send(1'b1, 8'hC0);
        do_reset(2);
        idle(4);
        check("reset_inflight_pulses", pulses - pc0, 0);
        settings(4, 8, 15);
        cap.delete();
        repeat (6) send(1'b1, 8'h80);
        idle(4);
        check("guard_count", cap.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("guard[%0d]", i), cap_at(i), 8'h80);

        // Random traffic with per-sample setting changes and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                if ($urandom_range(0, 9) == 0)
                    settings($urandom_range(0, MAXF), $urandom_range(0, 15), $urandom_range(0, 15));
                send($urandom_range(0, 9) < 7, 8'($urandom));
            end
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
